uart_tx_fifo_port: RTL and testbench
====================================

Name: uart_tx_fifo_port

Overview:
Memory-mapped UART transmitter peripheral on the processor's memory-map decoder, downstream of the core. It sits on the same bus slot style as the GPIO and UART ports: Address, DataIn, DataOut, Select, Write. CPU stores push bytes into an 8-deep TX FIFO. A baud-rate engine serialises them as 8N1, LSB first, on the tx pin. Status and divider registers are readable, so software polls instead of spinning on a busy bit per byte.

Parameters:
DATA_LENGTH, 32, bus data width
FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 115200, reset baud rate
DEFAULT_DIV, CLK_FREQ/BAUD (434), reset value of BAUDDIV

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset; wired straight from the board rst, not inverted
Address  in  32  decoder address; only Address[3:2] are decoded
DataIn  in  32  write data from the decoder
DataOut  out  32  read data to the decoder; combinational
Select  in  1  chip select from the decoder
Write  in  1  write strobe; qualified by Select
tx  out  1  serial output; idle high

Behaviour:
- Register map, offset = Address[3:2]:
  - 0 TXDATA: write-only. Write pushes DataIn[7:0]. Reads return 0.
  - 1 STATUS: read-only, except that any write clears OVF.
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (frame in progress), bit3 OVF (sticky).
    - bits[7:4] = FIFO count, saturating display at 15. Other bits 0.
  - 2 BAUDDIV: R/W, bits[15:0]. Writes of a value <2 store 2.
  - 3 CTRL: R/W, bit0 EN.
- DataOut = selected register when Select=1, else 32'd0.
- Reset (rst=0, asynchronous): tx=1, FIFO empty, count=0, OVF=0, BAUDDIV=DEFAULT_DIV, EN=1, state IDLE, DataOut=0.
- Push: one entry per clk edge while Select & Write & offset==0.
  - FIFO full and no pop on the same edge: data dropped, OVF set.
  - FIFO full with a pop on the same edge: push accepted, count unchanged.
- State machine:
  - IDLE: tx=1. If EN=1 and FIFO not empty, pop the head into the shift register, latch BAUDDIV into the bit timer, go to START.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: shift out bits 0..7, DIV cycles each, then STOP.
  - STOP: tx=1 for DIV cycles, then IDLE.
  - The IDLE→START check happens on the same edge STOP ends, so back-to-back frames have no extra idle cycle.
- Latency: a write to TXDATA with the FIFO empty, EN=1 and state IDLE at edge N puts the start bit on tx from edge N+2.
- Frame length is exactly 10*DIV cycles.
- Bit timer: loaded with DIV-1, counts down, advances the bit at 0.
- BAUDDIV is latched per frame. A write mid-frame takes effect at the next frame.
- EN cleared mid-frame: the current frame completes, then the block holds IDLE and keeps buffering writes.
- BUSY = (state != IDLE).
- Reset asserted mid-frame: tx returns to 1 immediately and all queued data is discarded.
- tx is driven from a flop, so there are no glitches.

Decomposition:
- Package uart_tx_pkg holds:
  - register offsets: TXDATA=2'd0, STATUS=2'd1, BAUDDIV=2'd2, CTRL=2'd3
  - the 2-bit state encoding: IDLE, START, DATA, STOP
  - STATUS bit positions
  - MIN_DIV=2
- One sub-module: sync_fifo_param.
  - Parameterised width and depth, with wrapping pointers and an explicit count.
  - Same async active-low reset.
  - push/pop/full/empty/count interface.
- The baud timer and serialiser stay in the top module.

Test Plan:
- Reset, then read STATUS → 0x0000_0002 (EMPTY) and BAUDDIV → 434; tx=1.
- BAUDDIV=4, write 0x55 to TXDATA → tx low from edge N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 4 high; BUSY high for 40 cycles.
- DIV=4, write 9 bytes 0x00..0x08 back-to-back while byte 0 is in flight → byte 0 popped on first write, 8 queued, no OVF; a 10th write sets OVF and STATUS bit3. Writing STATUS clears OVF. All 9 frames are contiguous with no gaps and are received in order.
- BAUDDIV write of 0 then readback → 2. BAUDDIV=8 written mid-frame at DIV=4 → current frame keeps 4 cycles/bit, next frame uses 8.
- CTRL EN=0 mid-frame with 2 bytes queued → frame finishes, tx idles high, count=2. EN=1 → transmission resumes.
- rst pulsed low mid-DATA → tx=1 asynchronously, STATUS=0x0000_0002 after release, no further frames.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// serialiser state encoding, STATUS bit layout and small helpers.
package uart_tx_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] MIN_DIV = 16'd2;

    // The count field is only four bits wide, so deeper FIFOs read as 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'd15 : c[3:0];
    endfunction

    // A divider below two would leave no room for the bit timer to count.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_port_if.sv
// Decoder-side bus slot shared by the memory-mapped peripherals.
// A transfer occurs on every rising clk edge with Select high: Write=1 is a store
// of DataIn, Write=0 a load; there are no wait states and DataOut is valid in the
// same cycle (combinational from Address/Select), reading 0 when Select is low.
interface uart_tx_fifo_port_if #(
    parameter int DATA_LENGTH = 32
);
    logic [31:0]            Address;
    logic [DATA_LENGTH-1:0] DataIn;
    logic [DATA_LENGTH-1:0] DataOut;
    logic                   Select;
    logic                   Write;

    modport master (
        output Address,
        output DataIn,
        output Select,
        output Write,
        input  DataOut
    );

    modport slave (
        input  Address,
        input  DataIn,
        input  Select,
        input  Write,
        output DataOut
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo_port.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, a per-frame
// latched baud divider paces the serialiser, status/divider/control are readable.
module uart_tx_fifo_port
    import uart_tx_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DEFAULT_DIV = CLK_FREQ / BAUD
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_fifo_port_if.slave  bus,
    output logic                tx,
    output tx_state_t           state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    logic [1:0]       offset;
    logic             wr_en;
    logic             push;
    logic             pop;
    logic [7:0]       head;
    logic             full;
    logic             empty;
    logic [CW-1:0]    fifo_count;

    logic             ovf;
    logic             en;
    logic [DIV_W-1:0] baud_div;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] bit_timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             timer_zero;
    logic             tx_next;
    logic             busy;

    logic [DATA_LENGTH-1:0] rdata;
    logic                   unused_bus;

    assign offset = bus.Address[3:2];
    assign wr_en  = bus.Select && bus.Write;
    assign push   = wr_en && (offset == OFF_TXDATA);
    assign busy   = (state != IDLE);
    assign unused_bus = ^{bus.Address[31:4], bus.Address[1:0], bus.DataIn[DATA_LENGTH-1:16]};

    sync_fifo_param #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.DataIn[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // A new frame can start from IDLE or on the very edge the stop bit ends.
    assign timer_zero = (bit_timer == '0);
    assign pop = en && !empty && ((state == IDLE) || (state == STOP && timer_zero));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            en       <= 1'b1;
            baud_div <= RESET_DIV;
        end else begin
            if (wr_en && offset == OFF_STATUS) begin
                ovf <= 1'b0;
            end else if (push && full && !pop) begin
                ovf <= 1'b1;
            end
            if (wr_en && offset == OFF_BAUDDIV) baud_div <= clamp_div(bus.DataIn[15:0]);
            if (wr_en && offset == OFF_CTRL)    en       <= bus.DataIn[0];
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift[0];
            default: tx_next = 1'b1;
        endcase
    end

    // tx follows the state one edge later, so the line comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_q     <= RESET_DIV;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx        <= 1'b1;
        end else begin
            tx <= tx_next;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= head;
                        div_q     <= baud_div;
                        bit_timer <= baud_div - DIV_W'(1);
                        state     <= START;
                    end
                end
                START: begin
                    if (timer_zero) begin
                        bit_timer <= div_q - DIV_W'(1);
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (timer_zero) begin
                        bit_timer <= div_q - DIV_W'(1);
                        shift     <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (timer_zero) begin
                        if (pop) begin
                            shift     <= head;
                            div_q     <= baud_div;
                            bit_timer <= baud_div - DIV_W'(1);
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.Select) begin
            case (offset)
                OFF_STATUS: begin
                    rdata[STAT_FULL]              = full;
                    rdata[STAT_EMPTY]             = empty;
                    rdata[STAT_BUSY]              = busy;
                    rdata[STAT_OVF]               = ovf;
                    rdata[STAT_CNT_LSB +: 4]      = sat_count(32'(fifo_count));
                end
                OFF_BAUDDIV: rdata[DIV_W-1:0] = baud_div;
                OFF_CTRL:    rdata[0]         = en;
                default:     rdata            = '0;
            endcase
        end
    end

    assign bus.DataOut = rdata;

endmodule

// File: tb/tb_uart_tx_fifo_port.sv
// Directed bench for uart_tx_fifo_port: register map, frame timing, FIFO overflow,
// per-frame divider latching, enable gating and asynchronous reset.
module tb_uart_tx_fifo_port;
    import uart_tx_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      tx;
    tx_state_t state;

    int n_checks = 0;
    int n_errs   = 0;

    uart_tx_fifo_port_if #(.DATA_LENGTH(32)) bus ();

    uart_tx_fifo_port #(
        .DATA_LENGTH (32),
        .FIFO_DEPTH  (8),
        .CLK_FREQ    (50_000_000),
        .BAUD        (115200)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .tx    (tx),
        .state (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] off, input logic [31:0] data);
        bus.Address = {28'd0, off, 2'b00};
        bus.DataIn  = data;
        bus.Select  = 1'b1;
        bus.Write   = 1'b1;
        tick();
        bus.Select  = 1'b0;
        bus.Write   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] off, output logic [31:0] val);
        bus.Address = {28'd0, off, 2'b00};
        bus.Select  = 1'b1;
        bus.Write   = 1'b0;
        #1;
        val = bus.DataOut;
        bus.Select  = 1'b0;
    endtask

    // Entered on the first start-bit sample; returns on the sample one frame later.
    task automatic check_frame(input logic [7:0] b, input int div, input bit watch,
                               output int busy_cnt);
        logic [9:0] obs;
        logic [9:0] exp;
        int         glitch;
        logic       s;
        obs      = '0;
        glitch   = 0;
        busy_cnt = 0;
        exp      = {1'b1, b, 1'b0};
        if (watch) begin
            bus.Address = {28'd0, OFF_STATUS, 2'b00};
            bus.Select  = 1'b1;
            bus.Write   = 1'b0;
            #1;
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < div; j++) begin
                s = tx;
                if (j == 0) obs[k] = s;
                else if (s !== obs[k]) glitch++;
                if (watch && bus.DataOut[STAT_BUSY] === 1'b1) busy_cnt++;
                tick();
            end
        end
        if (watch) bus.Select = 1'b0;
        chk($sformatf("frame_%02h", b), 32'(obs), 32'(exp));
        chk($sformatf("frame_%02h_stable", b), glitch, 0);
    endtask

    logic [31:0] rd_a;
    logic [31:0] rd_m;
    int          bc;
    int          bc_b;
    int          lows;

    initial begin
        rst         = 1'b0;
        bus.Address = {28'd0, OFF_STATUS, 2'b00};
        bus.DataIn  = '0;
        bus.Select  = 1'b0;
        bus.Write   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_dataout_unsel", bus.DataOut, 0);
        rst = 1'b1;
        tick();
        read_reg(OFF_STATUS, rd_m);  chk("rst_status", rd_m, 32'h2);
        read_reg(OFF_BAUDDIV, rd_m); chk("rst_bauddiv", rd_m, 434);
        read_reg(OFF_CTRL, rd_m);    chk("rst_ctrl", rd_m, 1);
        read_reg(OFF_TXDATA, rd_m);  chk("txdata_read", rd_m, 0);

        // Single frame, latency and busy window
        write_reg(OFF_BAUDDIV, 4);
        read_reg(OFF_BAUDDIV, rd_m); chk("bauddiv_4", rd_m, 4);
        write_reg(OFF_TXDATA, 32'h55);
        tick();
        chk("latency_n1_tx", tx, 1);
        read_reg(OFF_STATUS, rd_m); chk("status_n1", rd_m, 32'h6);
        tick();
        check_frame(8'h55, 4, 1'b1, bc);
        chk("busy_cycles", bc + 1, 40);
        read_reg(OFF_STATUS, rd_m); chk("status_after_55", rd_m, 32'h2);

        // Back-to-back bytes, overflow and OVF clear
        fork
            begin
                for (int i = 0; i < 9; i++) write_reg(OFF_TXDATA, 32'(i));
                read_reg(OFF_STATUS, rd_a); chk("status_full", rd_a, 32'h85);
                write_reg(OFF_TXDATA, 32'h09);
                read_reg(OFF_STATUS, rd_a); chk("status_ovf", rd_a, 32'h8D);
                write_reg(OFF_STATUS, 32'h0);
                read_reg(OFF_STATUS, rd_a); chk("status_ovf_clr", rd_a, 32'h85);
            end
            begin
                tick();
                tick();
                tick();
                for (int i = 0; i < 9; i++) check_frame(8'(i), 4, 1'b0, bc_b);
            end
        join
        chk("b2b_idle_tx", tx, 1);
        read_reg(OFF_STATUS, rd_m); chk("status_after_b2b", rd_m, 32'h2);

        // Divider clamp and per-frame latching
        write_reg(OFF_BAUDDIV, 0);
        read_reg(OFF_BAUDDIV, rd_m); chk("bauddiv_clamp", rd_m, 2);
        write_reg(OFF_BAUDDIV, 4);
        write_reg(OFF_TXDATA, 32'hA1);
        write_reg(OFF_TXDATA, 32'h3C);
        fork
            begin
                repeat (10) tick();
                write_reg(OFF_BAUDDIV, 8);
            end
            begin
                tick();
                check_frame(8'hA1, 4, 1'b0, bc_b);
                check_frame(8'h3C, 8, 1'b0, bc_b);
            end
        join
        read_reg(OFF_STATUS, rd_m); chk("status_after_div", rd_m, 32'h2);
        write_reg(OFF_BAUDDIV, 4);

        // Enable cleared mid-frame
        write_reg(OFF_TXDATA, 32'h11);
        write_reg(OFF_TXDATA, 32'h22);
        write_reg(OFF_TXDATA, 32'h33);
        fork
            begin
                repeat (5) tick();
                write_reg(OFF_CTRL, 0);
            end
            check_frame(8'h11, 4, 1'b0, bc_b);
        join
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("en0_idle_tx", lows, 0);
        read_reg(OFF_STATUS, rd_m); chk("status_en0", rd_m, 32'h20);
        read_reg(OFF_CTRL, rd_m);   chk("ctrl_en0", rd_m, 0);
        write_reg(OFF_CTRL, 1);
        tick();
        chk("en1_latency_tx", tx, 1);
        tick();
        check_frame(8'h22, 4, 1'b0, bc_b);
        check_frame(8'h33, 4, 1'b0, bc_b);
        read_reg(OFF_STATUS, rd_m); chk("status_after_en", rd_m, 32'h2);

        // Asynchronous reset in the middle of the data bits
        write_reg(OFF_TXDATA, 32'h5A);
        write_reg(OFF_TXDATA, 32'hC3);
        write_reg(OFF_TXDATA, 32'h99);
        repeat (12) tick();
        chk("pre_rst_tx_bit2", tx, 0);
        rst = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_state", 32'(state), 32'(IDLE));
        tick();
        tick();
        rst = 1'b1;
        read_reg(OFF_STATUS, rd_m); chk("status_post_rst", rd_m, 32'h2);
        read_reg(OFF_BAUDDIV, rd_m); chk("bauddiv_post_rst", rd_m, 434);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("post_rst_no_frames", lows, 0);
        read_reg(OFF_STATUS, rd_m); chk("status_final", rd_m, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
